// File: rtl/branch_resolve_update.sv
// rtl/branch_resolve_update.sv - branch resolve, BHT update, mispredict flush and statistics
//
// Owns the table of 2-bit saturating counters read by fetch. When a
// conditional branch resolves in EX it trains the indexed counter. On a
// mispredict it raises a registered one-cycle flush with the corrected PC.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_pc          PC being fetched; indexes the table for pred_taken
//   pred_taken        combinational prediction for fetch_pc (counter MSB)
//   ex_valid          EX stage holds a live instruction
//   ex_branch         EX instruction is a conditional branch
//   ex_taken          resolved outcome from the comparator
//   ex_pred_taken     prediction made at fetch, carried down the pipe
//   ex_pc, ex_target  PC and target of the EX instruction
//   flush             one-cycle squash/redirect pulse
//   redirect_pc       corrected fetch PC, valid while flush=1, held otherwise
//   branch_count      resolved branches since reset (wrapping)
//   mispredict_count  mispredictions since reset (wrapping)

module branch_resolve_update #(
  parameter int N     = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     fetch_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [N-1:0]     ex_pc,
  input  logic [N-1:0]     ex_target,
  output logic             flush,
  output logic [N-1:0]     redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int M = 2 ** IDX_W;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic [1:0]       bht [M];
  logic [0:0]       state;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       cur_cnt;
  logic [1:0]       next_cnt;
  logic             resolve;
  logic             mispredict;
  logic             unused_fetch_bits;

  // Word-aligned PCs: the low two bits and the bits above the index
  // carry no information for the table.
  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign unused_fetch_bits = ^{fetch_pc[N-1:IDX_W+2], fetch_pc[1:0]};

  // Read-before-write: the read sees the table as of the last edge, so a
  // same-cycle update to the same entry is not bypassed.
  assign pred_taken = bht[fetch_idx][1];

  // The EX instruction in the cycle after a mispredict is wrong-path.
  assign resolve    = ex_valid && ex_branch && (state == RUN);
  assign mispredict = resolve && (ex_taken != ex_pred_taken);

  always_comb begin
    cur_cnt  = bht[ex_idx];
    next_cnt = cur_cnt;
    if (ex_taken) begin
      if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'b01;
    end else begin
      if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) begin
        bht[i] <= 2'b10;
      end
      state            <= RUN;
      flush            <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      flush <= mispredict;
      state <= mispredict ? SQUASH : RUN;
      if (resolve) begin
        bht[ex_idx]  <= next_cnt;
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
        redirect_pc      <= ex_taken ? ex_target : (ex_pc + N'(4));
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_update.sv
// tb/tb_branch_resolve_update.sv - scoreboard bench for branch_resolve_update

module tb_branch_resolve_update;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic        prev_flush = 1'b0;

  branch_resolve_update #(.N(32), .IDX_W(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_taken         (ex_taken),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic t, input logic p,
                       input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid      = v;
    ex_branch     = b;
    ex_taken      = t;
    ex_pred_taken = p;
    ex_pc         = pc;
    ex_target     = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every flush pulse must match the next expected redirect.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flush", {31'b0, flush}, 32'h0);
        end else begin
          chk("redirect_pc", redirect_pc, exp_q.pop_front());
        end
        if (prev_flush) chk("flush_back_to_back", {31'b0, prev_flush}, 32'h0);
      end
      prev_flush = flush;
    end else begin
      prev_flush = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    fetch_pc = 32'h10;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_pred", {31'b0, pred_taken}, 32'h1);
    chk("reset_flush", {31'b0, flush}, 32'h0);
    chk("reset_redirect", redirect_pc, 32'h0);
    chk("reset_bc", {16'b0, branch_count}, 32'h0);
    chk("reset_mc", {16'b0, mispredict_count}, 32'h0);

    // Three correctly predicted taken resolves at idx 4: 10->11->11->11
    cyc();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h100);
    repeat (3) cyc();
    idle();
    @(negedge clk);
    chk("sat_bc", {16'b0, branch_count}, 32'd3);
    chk("sat_mc", {16'b0, mispredict_count}, 32'd0);
    chk("sat_pred", {31'b0, pred_taken}, 32'h1);

    // Not-taken, correctly predicted: 11->10 (pred stays 1 only if saturated)
    cyc();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    chk("sat_hold_pred", {31'b0, pred_taken}, 32'h1);
    chk("dec_bc", {16'b0, branch_count}, 32'd4);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    chk("dec_pred", {31'b0, pred_taken}, 32'h0);

    // Asynchronous reset between edges restores the table
    rst_n = 1'b0;
    #1;
    chk("rst2_bc", {16'b0, branch_count}, 32'h0);
    chk("rst2_pred", {31'b0, pred_taken}, 32'h1);
    #1 rst_n = 1'b1;

    // Not-taken mispredict from 10 at idx 4, fetch reads the same entry
    cyc();
    fetch_pc = 32'h10;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h999);
    exp_q.push_back(32'h14);
    @(negedge clk);
    chk("collision_pre", {31'b0, pred_taken}, 32'h1);
    cyc();
    idle();
    @(negedge clk);
    chk("collision_post", {31'b0, pred_taken}, 32'h0);
    chk("mp1_mc", {16'b0, mispredict_count}, 32'd1);
    chk("mp1_bc", {16'b0, branch_count}, 32'd1);
    chk("mp1_flush", {31'b0, flush}, 32'h1);
    cyc();
    @(negedge clk);
    chk("mp1_flush_drop", {31'b0, flush}, 32'h0);

    // Taken mispredict then a second mispredict during SQUASH (ignored),
    // then a non-branch that would look like a mispredict
    cyc();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h200);
    exp_q.push_back(32'h200);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h300);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h400);
    cyc();
    idle();
    @(negedge clk);
    chk("squash_bc", {16'b0, branch_count}, 32'd2);
    chk("squash_mc", {16'b0, mispredict_count}, 32'd2);
    chk("redirect_hold", redirect_pc, 32'h200);
    chk("squash_flush", {31'b0, flush}, 32'h0);
    fetch_pc = 32'h30;
    #1 chk("squash_no_update", {31'b0, pred_taken}, 32'h1);
    fetch_pc = 32'h40;
    #1 chk("nonbranch_no_update", {31'b0, pred_taken}, 32'h1);

    // Drive idx 4 to 00, then mispredict and reset while flush is high
    cyc();
    fetch_pc = 32'h10;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    repeat (2) cyc();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h500);
    cyc();
    idle();
    chk("pre_rst_pred", {31'b0, pred_taken}, 32'h0);
    chk("pre_rst_flush", {31'b0, flush}, 32'h1);
    chk("pre_rst_bc", {16'b0, branch_count}, 32'd5);
    chk("pre_rst_mc", {16'b0, mispredict_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_flush", {31'b0, flush}, 32'h0);
    chk("async_bc", {16'b0, branch_count}, 32'h0);
    chk("async_mc", {16'b0, mispredict_count}, 32'h0);
    chk("async_redirect", redirect_pc, 32'h0);
    chk("async_pred", {31'b0, pred_taken}, 32'h1);
    #1 rst_n = 1'b1;

    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_update.md
Name: branch_resolve_update

Overview:
- Write/resolve end of the branch prediction path. The fetch-side lookup reads a table of 2-bit saturating counters. This block owns that table and updates it when a branch resolves in EX, using the comparator's taken/not-taken result.
- Detects mispredictions, issues a registered one-cycle flush with the corrected PC, and keeps branch/mispredict statistics.
- Sits between the EX-stage branch comparator and the IF-stage PC mux.

Parameters:
- N, 32, PC/data width.
- IDX_W, 4, table index width; table depth M = 2**IDX_W entries.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- fetch_pc  input  N  PC currently being fetched.
- pred_taken  output  1  prediction for fetch_pc, equal to BHT[fetch_pc[IDX_W+1:2]][1]; combinational read.
- ex_valid  input  1  EX stage holds a live instruction.
- ex_branch  input  1  EX instruction is a conditional branch.
- ex_taken  input  1  resolved outcome from the comparator.
- ex_pred_taken  input  1  prediction made at fetch, carried down the pipe.
- ex_pc  input  N  PC of the EX instruction.
- ex_target  input  N  branch target address.
- flush  output  1  registered one-cycle pulse: squash IF/ID and redirect.
- redirect_pc  output  N  corrected fetch PC; valid while flush=1.
- branch_count  output  CNT_W  resolved branches since reset.
- mispredict_count  output  CNT_W  mispredictions since reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all M counters set to 2'b10 (weakly taken);
  - flush=0, redirect_pc=0, both statistics counters=0;
  - FSM set to RUN.
  - Reset mid-operation aborts any pending flush immediately.
- Index: idx(pc) = pc[IDX_W+1:2]. Bits [1:0] are ignored (word-aligned PCs).
- Resolve event: ex_valid && ex_branch && state==RUN.
- On a resolve event, at the clock edge:
  - BHT[idx(ex_pc)] increments if ex_taken=1, saturating at 2'b11;
  - it decrements if ex_taken=0, saturating at 2'b00;
  - branch_count increments.
- Mispredict = resolve event && (ex_taken != ex_pred_taken). On the same edge:
  - mispredict_count increments;
  - flush goes to 1 for exactly one cycle;
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4 (mod 2**N);
  - FSM goes RUN -> SQUASH.
- FSM states:
  - RUN: normal operation.
  - SQUASH: entered for exactly one cycle after a mispredict. The instruction in EX during this cycle is wrong-path. Resolve events are ignored: no BHT update, no counter change, no flush. Next state is always RUN.
- Latency:
  - pred_taken reflects the table contents from the previous edge (zero-cycle read).
  - Updates are visible to pred_taken on the cycle after the resolve edge.
- Read/write collision: if idx(fetch_pc) == idx(ex_pc) in the resolve cycle, pred_taken shows the pre-update value (read-before-write, no bypass).
- Statistics counters wrap modulo 2**CNT_W; no saturation.
- Non-branch or ex_valid=0 cycles: no state change. flush returns to 0.
- flush is never asserted in two consecutive cycles.
- redirect_pc holds its last value when flush=0.

Test Plan:
- Reset, then fetch_pc=0x0000_0010 -> pred_taken=1 (counter 2'b10); flush=0; branch_count=0; mispredict_count=0.
- Three resolve events at ex_pc=0x10, ex_taken=1, ex_pred_taken=1 -> counter saturates at 2'b11; no flush; branch_count=3; mispredict_count=0.
- From 2'b10 at idx 4, resolve ex_taken=0, ex_pred_taken=1, ex_pc=0x10 -> next cycle flush=1, redirect_pc=0x14; pred_taken for 0x10 flips to 0; mispredict_count=1; flush=0 the cycle after.
- Mispredict with ex_taken=1, ex_pred_taken=0, ex_target=0x200, followed immediately by another mispredicting resolve event -> one flush pulse with redirect_pc=0x200; the second event is ignored (SQUASH); branch_count increments by 1 only.
- fetch_pc and ex_pc both at index 4 in the same cycle as a not-taken update from 2'b10 -> pred_taken=1 that cycle, 0 the next.
- Assert rst_n=0 asynchronously in the same cycle a mispredict is registered -> flush=0, counters=0, and all BHT entries back to 2'b10 without waiting for a clock edge.
